// File: rtl/note_sequencer.sv
// note_sequencer: buffers {tone, duration} notes in a small FIFO and plays them
// back one at a time, inserting a silent gap between consecutive notes.
// Optional build macro SEQ_LOOP_EN adds a LOOP input that recirculates each
// played entry to the tail so the queue repeats until stopped or cleared.
// All outputs come straight from flops; next-state values are decoded once in
// the combinational block and registered.
module note_sequencer #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TICK_HZ        = 100,
  parameter int DUR_UNIT_TICKS = 10,
  parameter int GAP_TICKS      = 5,
  parameter int AW             = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          WR_EN,
  input  logic [3:0]    WR_TONE,
  input  logic [3:0]    WR_DUR,
  input  logic          PLAY,
  input  logic          STOP,
  input  logic          CLEAR,
`ifdef SEQ_LOOP_EN
  input  logic          LOOP,
`endif
  output logic [3:0]    TONE,
  output logic [3:0]    DURATION,
  output logic          BUSY,
  output logic          NOTE_DONE,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          OVF
);

  localparam int P        = CLK_HZ / TICK_HZ;
  localparam int PW       = (P > 1) ? $clog2(P) : 1;
  localparam int DEPTH    = 1 << AW;
  localparam int NOTE_MAX = 16 * DUR_UNIT_TICKS;
  localparam int CNT_MAX  = (NOTE_MAX > GAP_TICKS) ? NOTE_MAX : GAP_TICKS;
  localparam int CW       = $clog2(CNT_MAX + 1) + 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(P - 1);
  localparam logic [PW-1:0] PRE_ZERO  = PW'(0);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam bit            HAS_GAP   = (GAP_TICKS > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_NOTE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t          state_r;
  logic [PW-1:0]   pre_r;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      note_tone_r;
  logic [3:0]      note_dur_r;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            ovf_r;
  logic [3:0]      tone_out_r;
  logic            busy_r;
  logic            note_done_r;
  logic            empty_r;
  logic            full_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  state_t          state_next_s;
  logic [PW-1:0]   pre_next_s;
  logic [CW-1:0]   cnt_next_s;
  logic [3:0]      note_tone_next_s;
  logic [3:0]      note_dur_next_s;
  logic            pop_s;
  logic            tick_s;
  logic            abort_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic [7:0]      head_s;
  logic [CW-1:0]   load_cnt_s;
  logic            loop_s;
  logic            wr_block_s;
  logic            wr_req_s;
  logic            wr_ok_s;
  logic            push_s;
  logic [7:0]      push_data_s;
  logic            ovf_set_s;
  logic [AW:0]     count_next_s;
  logic [3:0]      tone_out_next_s;
  logic            note_done_next_s;

`ifdef SEQ_LOOP_EN
  assign loop_s = LOOP;
`else
  assign loop_s = 1'b0;
`endif

  assign tick_s       = (pre_r == PRE_LAST);
  assign fifo_empty_s = (count_r == OCC_ZERO);
  assign fifo_full_s  = (count_r == CNT_FULL);
  assign head_s       = mem_r[rd_ptr_r];
  assign load_cnt_s   = CW'(({28'd0, head_s[3:0]} + 32'd1) * 32'(DUR_UNIT_TICKS));
  // CLEAR outside IDLE doubles as STOP; STOP always takes priority over PLAY.
  assign abort_s      = STOP || (CLEAR && (state_r != S_IDLE));

  // Next-state, tick counter, prescaler and note latch decode.
  always_comb begin
    state_next_s     = state_r;
    cnt_next_s       = cnt_r;
    note_tone_next_s = note_tone_r;
    note_dur_next_s  = note_dur_r;
    pop_s            = 1'b0;
    if (tick_s) begin
      pre_next_s = PRE_ZERO;
    end else begin
      pre_next_s = pre_r + PRE_ONE;
    end

    case (state_r)
      S_IDLE: begin
        if (PLAY && !CLEAR && !fifo_empty_s) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: begin
        pop_s            = 1'b1;
        note_tone_next_s = head_s[7:4];
        note_dur_next_s  = head_s[3:0];
        cnt_next_s       = load_cnt_s;
        pre_next_s       = PRE_ZERO;
        state_next_s     = S_NOTE;
      end
      S_NOTE: begin
        if (tick_s) begin
          if (cnt_r <= CNT_ONE) begin
            if (HAS_GAP) begin
              cnt_next_s   = GAP_LOAD;
              state_next_s = S_GAP;
            end else if (!fifo_empty_s) begin
              state_next_s = S_LOAD;
            end else begin
              state_next_s = S_IDLE;
            end
          end else begin
            cnt_next_s = cnt_r - CNT_ONE;
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      S_GAP: begin
        if (tick_s) begin
          if (cnt_r <= CNT_ONE) begin
            if (!fifo_empty_s) begin
              state_next_s = S_LOAD;
            end else begin
              state_next_s = S_IDLE;
            end
          end else begin
            cnt_next_s = cnt_r - CNT_ONE;
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase

    // Abort returns to IDLE without consuming the head entry.
    if (abort_s) begin
      state_next_s     = S_IDLE;
      pop_s            = 1'b0;
      note_tone_next_s = note_tone_r;
      note_dur_next_s  = note_dur_r;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // FIFO write arbitration, occupancy and overflow decode.
  always_comb begin
    wr_block_s = loop_s && (state_r != S_IDLE);
    wr_req_s   = WR_EN && !CLEAR && !wr_block_s;
    wr_ok_s    = wr_req_s && (!fifo_full_s || pop_s);
    ovf_set_s  = wr_req_s && fifo_full_s && !pop_s;
    if (loop_s && pop_s) begin
      push_s      = 1'b1;
      push_data_s = head_s;
    end else begin
      push_s      = wr_ok_s;
      push_data_s = {WR_TONE, WR_DUR};
    end
    if (CLEAR) begin
      count_next_s = OCC_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + OCC_ONE;
        2'b01:   count_next_s = count_r - OCC_ONE;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Output decode from next-state values so every output is a flop.
  always_comb begin
    if (state_next_s == S_NOTE) begin
      tone_out_next_s = note_tone_next_s;
    end else begin
      tone_out_next_s = 4'd0;
    end
    // NOTE_DONE is high during the final NOTE cycle: the one whose tick
    // brings the counter to zero.
    note_done_next_s = (state_next_s == S_NOTE) && (cnt_next_s == CNT_ONE) &&
                       (pre_next_s == PRE_LAST);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // FSM state, prescaler, tick counter and latched note.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= S_IDLE;
      pre_r       <= PRE_ZERO;
      cnt_r       <= '0;
      note_tone_r <= 4'd0;
      note_dur_r  <= 4'd0;
    end else begin
      state_r     <= state_next_s;
      pre_r       <= pre_next_s;
      cnt_r       <= cnt_next_s;
      note_tone_r <= note_tone_next_s;
      note_dur_r  <= note_dur_next_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= OCC_ZERO;
      ovf_r    <= 1'b0;
    end else if (CLEAR) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= OCC_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // FIFO storage array.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else if (push_s && !CLEAR) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tone_out_r  <= 4'd0;
      busy_r      <= 1'b0;
      note_done_r <= 1'b0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
    end else begin
      tone_out_r  <= tone_out_next_s;
      busy_r      <= (state_next_s != S_IDLE);
      note_done_r <= note_done_next_s;
      empty_r     <= (count_next_s == OCC_ZERO);
      full_r      <= (count_next_s == CNT_FULL);
    end
  end

  assign TONE      = tone_out_r;
  assign DURATION  = note_dur_r;
  assign BUSY      = busy_r;
  assign NOTE_DONE = note_done_r;
  assign EMPTY     = empty_r;
  assign FULL      = full_r;
  assign COUNT     = count_r;
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with P=10, DUR_UNIT_TICKS=2,
// GAP_TICKS=1, AW=2. Expected tone segments {tone, run length} are queued
// before PLAY and popped against the segments observed while BUSY is high.
module tb_note_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic [3:0] WR_TONE = 4'd0;
  logic [3:0] WR_DUR = 4'd0;
  logic       PLAY = 1'b0;
  logic       STOP = 1'b0;
  logic       CLEAR = 1'b0;
`ifdef SEQ_LOOP_EN
  logic       LOOP = 1'b0;
`endif
  logic [3:0] TONE;
  logic [3:0] DURATION;
  logic       BUSY;
  logic       NOTE_DONE;
  logic       EMPTY;
  logic       FULL;
  logic [2:0] COUNT;
  logic       OVF;

  note_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .DUR_UNIT_TICKS(2), .GAP_TICKS(1), .AW(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_TONE(WR_TONE), .WR_DUR(WR_DUR),
    .PLAY(PLAY), .STOP(STOP), .CLEAR(CLEAR),
`ifdef SEQ_LOOP_EN
    .LOOP(LOOP),
`endif
    .TONE(TONE), .DURATION(DURATION), .BUSY(BUSY), .NOTE_DONE(NOTE_DONE),
    .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] tone;
    int         len;
  } seg_t;

  seg_t exp_q[$];
  seg_t act_q[$];
  int   done_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   timed_out;
  int   idle_cycle;

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [3:0] t, input logic [3:0] d);
    WR_EN = 1'b1; WR_TONE = t; WR_DUR = d;
    @(posedge CLK); #1;
    WR_EN = 1'b0;
  endtask

  task automatic pulse_play();
    PLAY = 1'b1;
    @(posedge CLK); #1;
    PLAY = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0;
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    @(posedge CLK); #1;
    CLEAR = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic add_exp(input logic [3:0] t, input int n);
    seg_t s;
    s.tone = t; s.len = n;
    exp_q.push_back(s);
  endtask

  // Records TONE runs while BUSY is high; cycle 1 is the cycle after PLAY.
  task automatic capture(input int budget);
    int         cyc;
    int         len;
    logic [3:0] cur;
    bit         fin;
    seg_t       s;
    act_q.delete(); done_q.delete();
    cyc = 1; len = 0; cur = 4'd0; fin = 1'b0; idle_cycle = -1;
    while (!fin && cyc <= budget) begin
      @(negedge CLK);
      if (NOTE_DONE) done_q.push_back(cyc);
      if (!BUSY) begin
        fin = 1'b1;
        idle_cycle = cyc;
      end else if (len > 0 && TONE == cur) begin
        len++;
      end else begin
        if (len > 0) begin
          s.tone = cur; s.len = len; act_q.push_back(s);
        end
        cur = TONE; len = 1;
      end
      cyc++;
    end
    if (len > 0) begin
      s.tone = cur; s.len = len; act_q.push_back(s);
    end
    timed_out = !fin;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    vectors++;
    if ({TONE, DURATION, BUSY, NOTE_DONE, EMPTY, FULL, COUNT, OVF} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values got tone=%0d dur=%0d busy=%b nd=%b empty=%b full=%b count=%0d ovf=%b want 0 0 0 0 1 0 0 0",
               TONE, DURATION, BUSY, NOTE_DONE, EMPTY, FULL, COUNT, OVF);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_note();
    push(4'd5, 4'd2);
    pulse_play();
    wait_cycles(20);
    vectors++;
    if (TONE !== 4'd5) begin
      miscompares++;
      $display("FAIL mid_note_tone got %0d want 5", TONE);
    end
    RST_N = 1'b0;
    #1;
    vectors++;
    if ({TONE, DURATION, BUSY, NOTE_DONE, EMPTY, FULL, COUNT, OVF} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got tone=%0d dur=%0d busy=%b empty=%b count=%0d want 0 0 0 1 0",
               TONE, DURATION, BUSY, EMPTY, COUNT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_note();
    seg_t e, a;
    exp_q.delete();
    add_exp(4'd0, 1); add_exp(4'd7, 80); add_exp(4'd0, 10);
    push(4'd7, 4'd3);
    pulse_play();
    capture(200);
    vectors++;
    if (timed_out) begin
      miscompares++;
      $display("FAIL single_timeout got busy still high want idle within 200");
    end
    vectors++;
    if (act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_segments got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a.tone !== e.tone || a.len != e.len) begin
        miscompares++;
        $display("FAIL single_seg got tone=%0d len=%0d want tone=%0d len=%0d", a.tone, a.len, e.tone, e.len);
      end
    end
    vectors++;
    if (done_q.size() != 1 || done_q[0] != 81) begin
      miscompares++;
      $display("FAIL single_note_done got %0d pulses first=%0d want 1 pulse at 81",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    vectors++;
    if (idle_cycle < 0 || idle_cycle > 93) begin
      miscompares++;
      $display("FAIL single_idle got cycle %0d want <=93", idle_cycle);
    end
  endtask

  task automatic test_back_to_back();
    seg_t e, a;
    exp_q.delete();
    add_exp(4'd0, 1); add_exp(4'd1, 20); add_exp(4'd0, 11); add_exp(4'd2, 20); add_exp(4'd0, 10);
    push(4'd1, 4'd0);
    push(4'd2, 4'd0);
    pulse_play();
    capture(200);
    vectors++;
    if (timed_out || act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_segments got %0d timeout=%b want %0d", act_q.size(), timed_out, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a.tone !== e.tone || a.len != e.len) begin
        miscompares++;
        $display("FAIL b2b_seg got tone=%0d len=%0d want tone=%0d len=%0d", a.tone, a.len, e.tone, e.len);
      end
    end
    vectors++;
    if (done_q.size() != 2 || done_q[0] != 21 || done_q[1] != 52) begin
      miscompares++;
      $display("FAIL b2b_note_done got %0d pulses want 2 at 21,52", done_q.size());
    end
    vectors++;
    if (EMPTY !== 1'b1 || COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_empty got empty=%b count=%0d want 1 0", EMPTY, COUNT);
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) push(4'(i + 1), 4'd0);
    vectors++;
    if (FULL !== 1'b1 || COUNT !== 3'd4 || EMPTY !== 1'b0 || OVF !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_full got full=%b count=%0d empty=%b ovf=%b want 1 4 0 0", FULL, COUNT, EMPTY, OVF);
    end
    push(4'd9, 4'd9);
    vectors++;
    if (OVF !== 1'b1 || COUNT !== 3'd4) begin
      miscompares++;
      $display("FAIL fifo_ovf got ovf=%b count=%0d want 1 4", OVF, COUNT);
    end
    pulse_clear();
    vectors++;
    if (COUNT !== 3'd0 || OVF !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_clear got count=%0d ovf=%b empty=%b full=%b want 0 0 1 0", COUNT, OVF, EMPTY, FULL);
    end
    CLEAR = 1'b1; WR_EN = 1'b1; WR_TONE = 4'd3; WR_DUR = 4'd3;
    @(posedge CLK); #1;
    CLEAR = 1'b0; WR_EN = 1'b0;
    vectors++;
    if (COUNT !== 3'd0 || EMPTY !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_beats_write got count=%0d empty=%b want 0 1", COUNT, EMPTY);
    end
    pulse_play();
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL play_when_empty got busy=%b want 0", BUSY);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_stop();
    seg_t e, a;
    push(4'd3, 4'd1);
    push(4'd4, 4'd1);
    STOP = 1'b1; PLAY = 1'b1;
    @(posedge CLK); #1;
    STOP = 1'b0; PLAY = 1'b0;
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0 || COUNT !== 3'd2) begin
      miscompares++;
      $display("FAIL stop_beats_play got busy=%b count=%0d want 0 2", BUSY, COUNT);
    end
    @(posedge CLK); #1;
    pulse_play();
    wait_cycles(10);
    vectors++;
    if (TONE !== 4'd3) begin
      miscompares++;
      $display("FAIL stop_first_tone got %0d want 3", TONE);
    end
    pulse_stop();
    @(negedge CLK);
    vectors++;
    if (TONE !== 4'd0 || BUSY !== 1'b0 || COUNT !== 3'd1) begin
      miscompares++;
      $display("FAIL stop_abort got tone=%0d busy=%b count=%0d want 0 0 1", TONE, BUSY, COUNT);
    end
    @(posedge CLK); #1;
    exp_q.delete();
    add_exp(4'd0, 1); add_exp(4'd4, 40); add_exp(4'd0, 10);
    pulse_play();
    capture(200);
    vectors++;
    if (timed_out || act_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL resume_segments got %0d timeout=%b want %0d", act_q.size(), timed_out, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      vectors++;
      if (a.tone !== e.tone || a.len != e.len) begin
        miscompares++;
        $display("FAIL resume_seg got tone=%0d len=%0d want tone=%0d len=%0d", a.tone, a.len, e.tone, e.len);
      end
    end
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    logic [3:0] seen[$];
    logic [3:0] prev;
    int         bad_count;
    logic [3:0] want;
    LOOP = 1'b1;
    push(4'd6, 4'd0);
    push(4'd8, 4'd0);
    pulse_play();
    prev = 4'd0; bad_count = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge CLK);
      if (COUNT !== 3'd2) bad_count++;
      if (TONE != 4'd0 && TONE != prev) seen.push_back(TONE);
      prev = TONE;
    end
    @(posedge CLK); #1;
    vectors++;
    if (bad_count != 0) begin
      miscompares++;
      $display("FAIL loop_count got %0d cycles with count!=2 want 0", bad_count);
    end
    vectors++;
    if (seen.size() < 4) begin
      miscompares++;
      $display("FAIL loop_notes got %0d notes want >=4", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      want = (i % 2 == 0) ? 4'd6 : 4'd8;
      vectors++;
      if (seen[i] !== want) begin
        miscompares++;
        $display("FAIL loop_order[%0d] got %0d want %0d", i, seen[i], want);
      end
    end
    pulse_stop();
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0 || TONE !== 4'd0) begin
      miscompares++;
      $display("FAIL loop_stop got busy=%b tone=%0d want 0 0", BUSY, TONE);
    end
    @(posedge CLK); #1;
    LOOP = 1'b0;
    pulse_clear();
  endtask
`endif

  initial begin
    #3;
    test_reset();
    RST_N = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_reset_mid_note();
    test_single_note();
    test_back_to_back();
    test_fifo_full();
    test_stop();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
